nes_joypad_target: RTL

//  I2C-style target that emulates the joypad end of the link driven by nes_bridge.

---
 rtl/nes_joypad_target_pkg.sv | 15 +
 rtl/i2c_line_sync.sv | 33 +++
 rtl/nes_joypad_target.sv | 131 +++++++++++++
 3 files changed

// File: rtl/nes_joypad_target_pkg.sv
// nes_joypad_target_pkg: joypad bit indices, default target address and FSM state encoding shared by initiator and target.
package nes_joypad_target_pkg;
  localparam logic [6:0] JOYP_ADDRESS = 7'h52;
  localparam int JOYP_A      = 0;
  localparam int JOYP_B      = 1;
  localparam int JOYP_SELECT = 2;
  localparam int JOYP_START  = 3;
  localparam int JOYP_UP     = 4;
  localparam int JOYP_DOWN   = 5;
  localparam int JOYP_LEFT   = 6;
  localparam int JOYP_RIGHT  = 7;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_TX, ST_TX_ACK, ST_RX, ST_RX_ACK
  } state_e;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes scl/sda and derives scl edge and START/STOP strobes.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  // bit 1 = scl, bit 0 = sda; both lines share depth so their relative order is kept
  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0] hist_q;
  logic [1:0] cur;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '1;
      hist_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {scl_i, sda_i}};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  assign cur        = sync_q[SYNC_STAGES-1];
  assign sda_o      = cur[0];
  assign scl_rise_o = cur[1] & ~hist_q[1];
  assign scl_fall_o = ~cur[1] & hist_q[1];
  assign start_o    = cur[1] & hist_q[1] & hist_q[0] & ~cur[0];
  assign stop_o     = cur[1] & hist_q[1] & ~hist_q[0] & cur[0];
endmodule

// File: rtl/nes_joypad_target.sv
// nes_joypad_target: I2C-style target serving active-low button bytes on read and latching written command bytes.
module nes_joypad_target
  import nes_joypad_target_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = JOYP_ADDRESS,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] buttons,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       busy
);
  logic sda_s, rise, fall, start, stop;
  state_e state_q;
  logic [2:0] cnt_q;
  logic ph_q, rw_q, sda_q, busy_q, cmd_valid_q;
  logic [7:0] sh_q, tx_q, cmd_q, rx_d;
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .scl_i(scl_in), .sda_i(sda_in),
    .sda_o(sda_s), .scl_rise_o(rise), .scl_fall_o(fall), .start_o(start), .stop_o(stop)
  );
  assign rx_d = {sh_q[6:0], sda_s};
  // ph_q splits each ACK slot into its drive half and its release half
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      ph_q        <= 1'b0;
      rw_q        <= 1'b0;
      sh_q        <= 8'h00;
      tx_q        <= 8'h00;
      sda_q       <= 1'b1;
      busy_q      <= 1'b0;
      cmd_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (start) begin
        state_q <= ST_ADDR;
        cnt_q   <= 3'd0;
        ph_q    <= 1'b0;
        sda_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else if (stop) begin
        state_q <= ST_IDLE;
        ph_q    <= 1'b0;
        sda_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR: if (rise) begin
            sh_q  <= rx_d;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_q    <= sda_s;
              state_q <= (rx_d[7:1] == ADDRESS) ? ST_ADDR_ACK : ST_IDLE;
            end
          end
          ST_ADDR_ACK: if (fall) begin
            if (!ph_q) begin
              sda_q  <= 1'b0;
              busy_q <= 1'b1;
              tx_q   <= ~buttons;
              ph_q   <= 1'b1;
            end else begin
              ph_q    <= 1'b0;
              sda_q   <= rw_q ? tx_q[7] : 1'b1;
              tx_q    <= rw_q ? {tx_q[6:0], 1'b0} : tx_q;
              cnt_q   <= rw_q ? 3'd1 : 3'd0;
              state_q <= rw_q ? ST_TX : ST_RX;
            end
          end
          // the first bit of a byte is presented on entry, so cnt wrapping to 0 marks the ACK slot
          ST_TX: if (fall) begin
            if (cnt_q == 3'd0) begin
              sda_q   <= 1'b1;
              state_q <= ST_TX_ACK;
            end else begin
              sda_q <= tx_q[7];
              tx_q  <= {tx_q[6:0], 1'b0};
              cnt_q <= cnt_q + 3'd1;
            end
          end
          ST_TX_ACK:
            if (rise && !ph_q) begin
              if (sda_s) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                tx_q <= ~buttons;
                ph_q <= 1'b1;
              end
            end else if (fall && ph_q) begin
              ph_q    <= 1'b0;
              sda_q   <= tx_q[7];
              tx_q    <= {tx_q[6:0], 1'b0};
              cnt_q   <= 3'd1;
              state_q <= ST_TX;
            end
          ST_RX: if (rise) begin
            sh_q  <= rx_d;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= ST_RX_ACK;
          end
          ST_RX_ACK: if (fall) begin
            if (!ph_q) begin
              sda_q       <= 1'b0;
              cmd_q       <= sh_q;
              cmd_valid_q <= 1'b1;
              ph_q        <= 1'b1;
            end else begin
              sda_q   <= 1'b1;
              ph_q    <= 1'b0;
              cnt_q   <= 3'd0;
              state_q <= ST_RX;
            end
          end
          default: ;
        endcase
      end
    end
  assign sda_out   = sda_q;
  assign busy      = busy_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
endmodule
